// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg
// Shared definitions for the NN core sample/result bridge:
//   code_t              - 4-bit code type used on the core's req_in / out_en buses
//   REQ_NEXT            - req_in code that advances the presented sample
//   OUT_VALID           - out_en code that marks core_out as a valid result
//   IN_W_DEFAULT/OUT_W_DEFAULT - default sample / result widths of the core
package nn_stream_pkg;

    typedef logic [3:0] code_t;

    localparam code_t REQ_NEXT  = 4'd1;
    localparam code_t OUT_VALID = 4'd1;

    localparam int IN_W_DEFAULT  = 19;
    localparam int OUT_W_DEFAULT = 28;

endpackage

// File: rtl/nn_stream_bridge_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   wr_en_i     - write request; ignored while full (full is taken from the
//                 registered count, so a same-cycle read does not free a slot)
//   wr_data_i   - write data
//   rd_en_i     - read request; ignored while empty
//   rd_data_o   - current head word (undefined contents while empty)
//   count_o     - number of stored words, clog2(DEPTH)+1 bits
//   full_o      - count_o == DEPTH
//   empty_o     - count_o == 0
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             wr_fire, rd_fire;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_fire);
        rd_ptr_d = rd_ptr_q + AW'(rd_fire);
        count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_ptr_q];

endmodule

// File: rtl/nn_stream_bridge.sv
// nn_stream_bridge
// Feeds input samples to the NN core on its "next sample" request code and
// captures its results on the "output valid" code, with FIFOs on both sides.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   s_data/s_valid/s_ready      - upstream sample stream (valid/ready)
//   smp_out/smp_valid  - sample presented to the core and its validity
//   req_in             - core request code (REQ_NEXT advances the sample)
//   core_out/out_en    - core result and its output code (OUT_VALID captures)
//   m_data/m_valid/m_ready      - downstream result stream (valid/ready)
//   underrun/overflow  - sticky error flags, cleared by clr_flags
module nn_stream_bridge
    import nn_stream_pkg::*;
#(
    parameter int IN_W      = IN_W_DEFAULT,
    parameter int OUT_W     = OUT_W_DEFAULT,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [IN_W-1:0]  smp_out,
    output logic                    smp_valid,
    input  code_t                   req_in,
    input  logic signed [OUT_W-1:0] core_out,
    input  code_t                   out_en,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    underrun,
    output logic                    overflow,
    input  logic                    clr_flags
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    logic [IN_W-1:0]   in_head;
    logic [IN_CW-1:0]  in_count;
    logic              in_full, in_empty, in_pop;
    logic [OUT_W-1:0]  out_head;
    logic [OUT_CW-1:0] out_count;
    logic              out_full, out_empty, out_pop;

    logic              req_next, res_push;
    logic              underrun_set, overflow_set;

    logic signed [IN_W-1:0] smp_out_q, smp_out_d;
    logic                   smp_valid_q, smp_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;

    assign req_next = (req_in == REQ_NEXT);
    assign res_push = (out_en == OUT_VALID);

    assign s_ready = !in_full;

    // Pop the input FIFO both to refill an empty presentation register and
    // to advance on a request; the two cases collapse into a single pop.
    assign in_pop = !in_empty && (req_next || !smp_valid_q);

    sync_fifo #(.WIDTH(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (s_valid && s_ready),
        .wr_data_i (s_data),
        .rd_en_i   (in_pop),
        .rd_data_o (in_head),
        .count_o   (in_count),
        .full_o    (in_full),
        .empty_o   (in_empty)
    );

    // m_valid comes straight from the registered count, never from m_ready.
    assign m_valid = (out_count != '0);
    assign out_pop = m_valid && m_ready;
    assign m_data  = out_empty ? '0 : out_head;

    sync_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (res_push),
        .wr_data_i (core_out),
        .rd_en_i   (out_pop),
        .rd_data_o (out_head),
        .count_o   (out_count),
        .full_o    (out_full),
        .empty_o   (out_empty)
    );

    assign underrun_set = req_next && in_empty;
    assign overflow_set = res_push && out_full;

    always_comb begin
        smp_out_d   = smp_out_q;
        smp_valid_d = smp_valid_q;
        if (in_pop) begin
            smp_out_d   = in_head;
            smp_valid_d = 1'b1;
        end else if (req_next) begin
            // Request with nothing queued: keep the old value, mark it stale.
            smp_valid_d = 1'b0;
        end
        // A set event in the same cycle as the clear takes priority.
        underrun_d = underrun_set || (underrun_q && !clr_flags);
        overflow_d = overflow_set || (overflow_q && !clr_flags);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_out_q   <= '0;
            smp_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            smp_out_q   <= smp_out_d;
            smp_valid_q <= smp_valid_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    assign smp_out   = smp_out_q;
    assign smp_valid = smp_valid_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nn_stream_bridge.sv
// tb_nn_stream_bridge
// Self-checking bench for nn_stream_bridge: scoreboard queues hold the
// samples/results expected at the core and downstream sides.
module tb_nn_stream_bridge;

    localparam int IN_W  = 19;
    localparam int OUT_W = 28;
    localparam logic [3:0] REQ = 4'd1;
    localparam logic [3:0] OV  = 4'd1;

    logic                    clk;
    logic                    rst;
    logic signed [IN_W-1:0]  s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  smp_out;
    logic                    smp_valid;
    logic [3:0]              req_in;
    logic signed [OUT_W-1:0] core_out;
    logic [3:0]              out_en;
    logic signed [OUT_W-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    underrun;
    logic                    overflow;
    logic                    clr_flags;

    nn_stream_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .IN_DEPTH(8), .OUT_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .smp_out   (smp_out),
        .smp_valid (smp_valid),
        .req_in    (req_in),
        .core_out  (core_out),
        .out_en    (out_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .underrun  (underrun),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    logic signed [IN_W-1:0]  in_q [$];
    logic signed [OUT_W-1:0] out_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vec++; if (smp_out !== '0)   begin errs++; $display("FAIL rst_smp_out got %0d want 0", smp_out); end
        vec++; if (smp_valid !== 1'b0) begin errs++; $display("FAIL rst_smp_valid got %b want 0", smp_valid); end
        vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
        vec++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        vec++; if (m_data !== '0)    begin errs++; $display("FAIL rst_m_data got %0d want 0", m_data); end
        vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL rst_underrun got %b want 0", underrun); end
        vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow got %b want 0", overflow); end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_sample_path();
        logic signed [IN_W-1:0] exp_s;
        s_valid = 1'b1;
        s_data  = IN_W'(5);
        in_q.push_back(s_data);
        step();
        vec++; if (smp_valid !== 1'b0) begin errs++; $display("FAIL lat_cycle1 smp_valid got %b want 0", smp_valid); end
        s_data = IN_W'(-3);
        in_q.push_back(s_data);
        step();
        exp_s = in_q.pop_front();
        vec++; if (smp_valid !== 1'b1) begin errs++; $display("FAIL lat_cycle2 smp_valid got %b want 1", smp_valid); end
        vec++; if (smp_out !== exp_s)  begin errs++; $display("FAIL first_sample got %0d want %0d", smp_out, exp_s); end
        s_data = IN_W'(100);
        in_q.push_back(s_data);
        step();
        s_valid = 1'b0;
        req_in  = REQ;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_s = in_q.pop_front();
            vec++; if (smp_out !== exp_s || smp_valid !== 1'b1)
                begin errs++; $display("FAIL advance%0d got %0d/%b want %0d/1", i, smp_out, smp_valid, exp_s); end
        end
        step();
        vec++; if (underrun !== 1'b1)  begin errs++; $display("FAIL underrun_set got %b want 1", underrun); end
        vec++; if (smp_valid !== 1'b0) begin errs++; $display("FAIL underrun_valid got %b want 0", smp_valid); end
        vec++; if (smp_out !== exp_s)  begin errs++; $display("FAIL underrun_hold got %0d want %0d", smp_out, exp_s); end
        req_in = 4'd0;
        step();
        vec++; if (underrun !== 1'b1)  begin errs++; $display("FAIL underrun_sticky got %b want 1", underrun); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        vec++; if (underrun !== 1'b0)  begin errs++; $display("FAIL underrun_clr got %b want 0", underrun); end
    endtask

    task automatic test_ignore_codes();
        logic signed [IN_W-1:0] exp_s;
        s_valid = 1'b1;
        s_data  = IN_W'(7);
        in_q.push_back(s_data);
        step();
        s_data = IN_W'(8);
        in_q.push_back(s_data);
        step();
        s_valid = 1'b0;
        exp_s = in_q.pop_front();
        vec++; if (smp_out !== exp_s || smp_valid !== 1'b1)
            begin errs++; $display("FAIL ign_prefetch got %0d/%b want %0d/1", smp_out, smp_valid, exp_s); end
        req_in = 4'd2;
        step();
        vec++; if (smp_out !== exp_s) begin errs++; $display("FAIL ign_code2 got %0d want %0d", smp_out, exp_s); end
        req_in = 4'd0;
        step();
        vec++; if (smp_out !== exp_s) begin errs++; $display("FAIL ign_code0 got %0d want %0d", smp_out, exp_s); end
        req_in = REQ;
        step();
        req_in = 4'd0;
        exp_s = in_q.pop_front();
        vec++; if (smp_out !== exp_s) begin errs++; $display("FAIL ign_nopop got %0d want %0d", smp_out, exp_s); end
        vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL ign_underrun got %b want 0", underrun); end
    endtask

    task automatic test_input_full();
        logic signed [IN_W-1:0] exp_s;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = IN_W'(10 + i);
            in_q.push_back(s_data);
            step();
        end
        vec++; if (s_ready !== 1'b0) begin errs++; $display("FAIL full_s_ready got %b want 0", s_ready); end
        // 9th sample offered in the same cycle as a pop: must still be refused.
        s_data = IN_W'(99);
        req_in = REQ;
        step();
        s_valid = 1'b0;
        exp_s = in_q.pop_front();
        vec++; if (smp_out !== exp_s) begin errs++; $display("FAIL full_pop got %0d want %0d", smp_out, exp_s); end
        vec++; if (s_ready !== 1'b1)  begin errs++; $display("FAIL full_ready_back got %b want 1", s_ready); end
        for (int i = 0; i < 7; i++) begin
            step();
            exp_s = in_q.pop_front();
            vec++; if (smp_out !== exp_s || smp_valid !== 1'b1)
                begin errs++; $display("FAIL full_drain%0d got %0d/%b want %0d/1", i, smp_out, smp_valid, exp_s); end
        end
        step();
        req_in = 4'd0;
        vec++; if (smp_valid !== 1'b0 || smp_out !== exp_s)
            begin errs++; $display("FAIL full_9th_dropped got %0d/%b want %0d/0", smp_out, smp_valid, exp_s); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic test_output_overflow();
        int vals [5] = '{-1, 2, 3, 4, 5};
        int n;
        m_ready = 1'b0;
        out_en  = OV;
        for (int i = 0; i < 5; i++) begin
            core_out = OUT_W'(vals[i]);
            if (out_q.size() < 4) out_q.push_back(core_out);
            step();
            if (i == 0) begin
                vec++; if (m_valid !== 1'b1 || m_data !== out_q[0])
                    begin errs++; $display("FAIL ov_first got %0d/%b want %0d/1", m_data, m_valid, out_q[0]); end
            end
            if (i == 3) begin
                vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL ov_early got %b want 0", overflow); end
            end
        end
        out_en = 4'd0;
        vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL ov_set got %b want 1", overflow); end
        m_ready = 1'b1;
        n = out_q.size();
        for (int i = 0; i < n; i++) begin
            vec++; if (m_valid !== 1'b1 || m_data !== out_q[0])
                begin errs++; $display("FAIL ov_drain%0d got %0d/%b want %0d/1", i, m_data, m_valid, out_q[0]); end
            void'(out_q.pop_front());
            step();
        end
        m_ready = 1'b0;
        vec++; if (m_valid !== 1'b0 || m_data !== '0)
            begin errs++; $display("FAIL ov_empty got %0d/%b want 0/0", m_data, m_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL b2b_clr got %b want 0", overflow); end
        out_en = OV;
        core_out = OUT_W'(28'h111); out_q.push_back(core_out); step();
        core_out = OUT_W'(28'h222); out_q.push_back(core_out); step();
        // Push and pop together at count 2.
        core_out = OUT_W'(28'h333);
        m_ready  = 1'b1;
        vec++; if (m_data !== out_q[0]) begin errs++; $display("FAIL b2b_head got %0h want %0h", m_data, out_q[0]); end
        void'(out_q.pop_front());
        out_q.push_back(core_out);
        step();
        out_en = 4'd0;
        for (int i = 0; i < 2; i++) begin
            vec++; if (m_valid !== 1'b1 || m_data !== out_q[0])
                begin errs++; $display("FAIL b2b_order%0d got %0h/%b want %0h/1", i, m_data, m_valid, out_q[0]); end
            void'(out_q.pop_front());
            step();
        end
        m_ready = 1'b0;
        vec++; if (m_valid !== 1'b0) begin errs++; $display("FAIL b2b_count got m_valid %b want 0", m_valid); end
        // Fill, then overflow in the same cycle as a clear.
        out_en = OV;
        for (int i = 0; i < 4; i++) begin
            core_out = OUT_W'(i + 40);
            out_q.push_back(core_out);
            step();
        end
        core_out  = OUT_W'(999);
        clr_flags = 1'b1;
        step();
        out_en    = 4'd0;
        clr_flags = 1'b0;
        vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL clr_vs_set got %b want 1", overflow); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL clr_alone got %b want 0", overflow); end
        m_ready = 1'b1;
        n = out_q.size();
        for (int i = 0; i < n; i++) begin
            vec++; if (m_data !== out_q[0])
                begin errs++; $display("FAIL full_drain_out%0d got %0d want %0d", i, m_data, out_q[0]); end
            void'(out_q.pop_front());
            step();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        req_in = REQ;
        step();
        req_in = 4'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = IN_W'(200 + i);
            step();
        end
        s_valid = 1'b0;
        out_en = OV;
        core_out = OUT_W'(-7); step();
        core_out = OUT_W'(8);  step();
        out_en = 4'd0;
        vec++; if (smp_valid !== 1'b1 || m_valid !== 1'b1 || underrun !== 1'b1)
            begin errs++; $display("FAIL pre_rst got %b/%b/%b want 1/1/1", smp_valid, m_valid, underrun); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vec++; if (smp_valid !== 1'b0 || smp_out !== '0)
            begin errs++; $display("FAIL arst_smp got %0d/%b want 0/0", smp_out, smp_valid); end
        vec++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0)
            begin errs++; $display("FAIL arst_fifo got %b/%b/%0d want 1/0/0", s_ready, m_valid, m_data); end
        vec++; if (underrun !== 1'b0 || overflow !== 1'b0)
            begin errs++; $display("FAIL arst_flags got %b/%b want 0/0", underrun, overflow); end
        step();
        rst = 1'b1;
        step();
        step();
        vec++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || smp_valid !== 1'b0)
            begin errs++; $display("FAIL post_rst got %b/%b/%b want 1/0/0", s_ready, m_valid, smp_valid); end
        in_q.delete();
        out_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vec);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst       = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        req_in    = 4'd0;
        core_out  = '0;
        out_en    = 4'd0;
        m_ready   = 1'b0;
        clr_flags = 1'b0;
        test_reset();
        test_sample_path();
        test_ignore_codes();
        test_input_full();
        test_output_overflow();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/nn_stream_bridge.md
# nn_stream_bridge

Hardware-side counterpart of the neural-network core's sample/result interface. It serves input samples to the core when the core issues a "next sample" code on `req_in`, and captures results when the core signals a valid result on `out_en`. Both sides are decoupled by FIFOs: upstream uses valid/ready, downstream uses valid/ready. It sits between the acquisition stream and the `teste`-style core, and replaces the file-driven stimulus/capture used in simulation.

## Interface
- `IN_W`, 19: signed input sample width; matches core `in`.
- `OUT_W`, 28: signed result width; matches core `io_out`.
- `IN_DEPTH`, 8: input FIFO depth; power of two, ≥2.
- `OUT_DEPTH`, 4: output FIFO depth; power of two, ≥2.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  IN_W  upstream sample, signed.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  input FIFO not full.
- `smp_out`  out  IN_W  current sample presented to core `in`.
- `smp_valid`  out  1  `smp_out` holds an unconsumed real sample.
- `req_in`  in  4  core request code; `REQ_NEXT` = 4'd1 advances the sample.
- `core_out`  in  OUT_W  core result (`io_out`).
- `out_en`  in  4  core output code; `OUT_VALID` = 4'd1 marks `core_out` valid.
- `m_data`  out  OUT_W  downstream result (FIFO head; 0 when empty).
- `m_valid`  out  1  output FIFO not empty.
- `m_ready`  in  1  downstream accepts.
- `underrun`  out  1  sticky: request arrived with no sample available.
- `overflow`  out  1  sticky: result arrived with output FIFO full.
- `clr_flags`  in  1  synchronous clear of both sticky flags.

## Operation
- Input path: write on `s_valid && s_ready`; when full, `s_ready` = 0 and no write is accepted, even if a pop happens in the same cycle.
- Presentation register (`smp_out`, `smp_valid`):
  - Prefetch: if `smp_valid` = 0 and the FIFO is non-empty, pop the head into `smp_out` and set `smp_valid`.
  - Advance: on an edge with `req_in == REQ_NEXT` and the FIFO non-empty, pop the head into `smp_out`. `smp_valid` stays 1.
  - Underrun: on an edge with `req_in == REQ_NEXT` and the FIFO empty, `smp_out` holds its value, `smp_valid` goes to 0, and `underrun` is set. The next arriving sample is prefetched normally.
  - Any other `req_in` code is ignored.
- Output path: on an edge with `out_en == OUT_VALID`, push `core_out` if not full. If full, drop the result and set `overflow`. Other codes are ignored.
- Downstream pop on `m_valid && m_ready`. Push and pop in the same cycle are both legal when not full; when full, the push is dropped (full is evaluated before the pop).
- `clr_flags` clears both flags. A set event in the same cycle wins.
- Arithmetic: none. Data passes bit-exact; no sign extension or truncation.

## Timing
- Reset values: `smp_out` = 0, `smp_valid` = 0, `s_ready` = 1, `m_valid` = 0, `m_data` = 0, `underrun` = 0, `overflow` = 0. FIFO pointers and counts = 0; memories are not reset.
- Latency from upstream accept into an empty bridge to `smp_valid` = 1: 2 cycles (FIFO write, then prefetch).
- `REQ_NEXT` sampled at edge N → new `smp_out` visible after edge N. The core reads it from cycle N+1.
- `out_en` sampled at edge N → `m_valid` = 1 after edge N, with `m_data` = the captured `core_out`.
- `s_ready` and `m_valid` are derived from registered counts only; there is no combinational path from `s_valid` or `m_ready`.
- Pointers wrap modulo depth. Full/empty come from a count of width clog2(depth)+1.
- Reset asserted mid-operation: both FIFOs flush, `smp_valid` drops immediately, and all in-flight data is lost.

## Structure
- Package `nn_stream_pkg`: `REQ_NEXT` and `OUT_VALID` codes, default `IN_W`/`OUT_W`, and a code typedef `logic [3:0]`.
- Sub-module `sync_fifo`: parameterised width/depth, first-word-fall-through head, count/full/empty outputs, async active-low reset. Instantiated twice: input and output.
- Top level holds the presentation register, code decode, and sticky flags.

## Test plan
- Reset, then write samples 5, -3, 100 → `smp_out` = 5 with `smp_valid` = 1 two cycles after the first accept. Three `REQ_NEXT` pulses → `smp_out` steps -3, 100; the third pulse sets `underrun`, clears `smp_valid`, and `smp_out` holds 100.
- `req_in` = 4'd2 and 4'd0 with samples queued → `smp_out` unchanged and no pop.
- Fill the input FIFO with 8 samples → `s_ready` = 0. A 9th `s_valid` is not accepted. One `REQ_NEXT` → `s_ready` returns to 1 the next cycle.
- `out_en` = 1 five times with `core_out` = -1, 2, 3, 4, 5 and `m_ready` = 0 → first four queued, `overflow` set. Then `m_ready` = 1 → `m_data` sequence -1, 2, 3, 4, then `m_valid` = 0.
- Simultaneous `out_en` push and `m_ready` pop at count 2 → count stays 2 and ordering is preserved. `clr_flags` together with an overflow event → `overflow` stays 1.
- Assert `rst` = 0 with 3 samples queued and 2 results pending → all outputs return to reset values asynchronously; after release, `s_ready` = 1 and `m_valid` = 0.
